// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED averager scheduler.
//   sched_state_t : scheduler FSM states
//   MAG_MAX       : largest representable magnitude
//   abs_sat16     : signed 16-bit -> saturated magnitude
package led_sched_pkg;

  typedef enum logic [1:0] {IDLE, SEQ, SETTLE, CAPT} sched_state_t;

  localparam logic [15:0] MAG_MAX = 16'h7FFF;

  // -32768 has no positive twin in 16 bits, so clamp it to MAG_MAX.
  function automatic logic [15:0] abs_sat16(input logic signed [15:0] x);
    if (x == -16'sd32768) return MAG_MAX;
    else if (x < 0)       return 16'(-x);
    else                  return 16'(x);
  endfunction

endpackage

// File: rtl/led_rr_arb.sv
// Combinational round-robin search over a request vector.
//   i_req : per-band request
//   i_ptr : band with highest priority this round
//   o_vld : some band is requesting
//   o_idx : first requesting band at or after i_ptr (circular)
//   o_gnt : one-hot of o_idx (zero when !o_vld)
module led_rr_arb #(
  parameter int NUM_BANDS = 4,
  parameter int BAND_W    = $clog2(NUM_BANDS)
) (
  input  logic [NUM_BANDS-1:0] i_req,
  input  logic [BAND_W-1:0]    i_ptr,
  output logic                 o_vld,
  output logic [BAND_W-1:0]    o_idx,
  output logic [NUM_BANDS-1:0] o_gnt
);

  int b;

  // Walk offsets from far to near so the nearest requester wins last.
  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    o_gnt = '0;
    b     = 0;
    for (int k = NUM_BANDS - 1; k >= 0; k--) begin
      b = int'(i_ptr) + k;
      if (b >= NUM_BANDS) b = b - NUM_BANDS;
      if (i_req[b]) begin
        o_vld = 1'b1;
        o_idx = BAND_W'(b);
        o_gnt = '0;
        o_gnt[b] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_avg_sched.sv
// Round-robin scheduler time-sharing one LED averager among NUM_BANDS bands.
// Each grant drives a WIN_LEN-cycle sequencing window with the band's sample
// magnitude, waits SETTLE cycles, then captures the averager output.
//   clk, rst   : clock, synchronous active-high reset
//   band_req   : per-band level request
//   band_smpl  : signed 16-bit samples, band b at [16b+15:16b]
//   band_gnt   : one-hot grant, only while sequencing
//   avg_seq    : averager "sequencing"
//   avg_smpl   : averager "smpl_in" (registered magnitude)
//   avg_out    : averager "smpl_out"
//   lvl_out    : per-band captured levels
//   lvl_vld    : one-cycle pulse, aligned with the updated lvl_out
//   lvl_band   : band index for lvl_vld
//   busy       : scheduler not idle
//   pk_out     : per-band peak-hold (only with LED_SCHED_PEAK_EN)
// Optional feature macro: LED_SCHED_PEAK_EN
module led_avg_sched import led_sched_pkg::*; #(
  parameter  int NUM_BANDS = 4,
  parameter  int WIN_LEN   = 1022,
  parameter  int SETTLE    = 3,
  localparam int BAND_W    = $clog2(NUM_BANDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_BANDS-1:0]    band_req,
  input  logic [16*NUM_BANDS-1:0] band_smpl,
  output logic [NUM_BANDS-1:0]    band_gnt,
  output logic                    avg_seq,
  output logic [15:0]             avg_smpl,
  input  logic [15:0]             avg_out,
  output logic [16*NUM_BANDS-1:0] lvl_out,
  output logic                    lvl_vld,
  output logic [BAND_W-1:0]       lvl_band,
`ifdef LED_SCHED_PEAK_EN
  output logic [16*NUM_BANDS-1:0] pk_out,
`endif
  output logic                    busy
);

  localparam int CNT_MAX = (WIN_LEN > SETTLE) ? WIN_LEN : SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // The SETTLE parameter shadows the enum literal, so the state is qualified.
  sched_state_t                r_state, w_nxt;
  logic [CNT_W-1:0]            r_cnt;
  logic [BAND_W-1:0]           r_cur, r_ptr, r_band;
  logic [15:0]                 r_smpl;
  logic [NUM_BANDS-1:0][15:0]  r_lvl;
  logic                        r_vld;

  logic                        w_arb_vld;
  logic [BAND_W-1:0]           w_arb_idx;
  logic [NUM_BANDS-1:0]        w_arb_gnt;
  logic [BAND_W-1:0]           w_sel;
  logic [15:0]                 w_mag;

  led_rr_arb #(.NUM_BANDS(NUM_BANDS), .BAND_W(BAND_W)) u_arb (
    .i_req (band_req),
    .i_ptr (r_ptr),
    .o_vld (w_arb_vld),
    .o_idx (w_arb_idx),
    .o_gnt (w_arb_gnt)
  );

  // In IDLE the sample register is preloaded from the band about to be
  // granted, so the first sequencing cycle already carries valid data.
  assign w_sel = (r_state == IDLE) ? w_arb_idx : r_cur;
  assign w_mag = abs_sat16(band_smpl[16*w_sel +: 16]);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt    = r_state;
    band_gnt = '0;
    avg_seq  = 1'b0;
    unique case (r_state)
      IDLE: if (w_arb_vld) w_nxt = SEQ;
      SEQ: begin
        avg_seq         = 1'b1;
        band_gnt[r_cur] = 1'b1;
        if (r_cnt == CNT_W'(WIN_LEN - 1)) w_nxt = led_sched_pkg::SETTLE;
      end
      led_sched_pkg::SETTLE:
        if (r_cnt == CNT_W'(SETTLE - 1)) w_nxt = CAPT;
      CAPT:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

`ifdef LED_SCHED_PEAK_EN
  logic [NUM_BANDS-1:0][15:0] r_pk;
  logic [15:0]                w_pk_dec;
  assign w_pk_dec = r_pk[r_cur] - (r_pk[r_cur] >> 4);
  assign pk_out   = r_pk;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_cur  <= '0;
      r_ptr  <= '0;
      r_band <= '0;
      r_smpl <= '0;
      r_lvl  <= '0;
      r_vld  <= 1'b0;
`ifdef LED_SCHED_PEAK_EN
      r_pk   <= '0;
`endif
    end else begin
      r_vld <= 1'b0;
      unique case (r_state)
        IDLE: if (w_arb_vld) begin
          r_cur  <= w_arb_idx;
          r_cnt  <= '0;
          r_smpl <= w_mag;
        end
        SEQ: begin
          r_smpl <= w_mag;
          r_cnt  <= (w_nxt == SEQ) ? r_cnt + 1'b1 : '0;
        end
        led_sched_pkg::SETTLE:
          r_cnt <= (w_nxt == CAPT) ? '0 : r_cnt + 1'b1;
        CAPT: begin
          r_lvl[r_cur] <= avg_out;
          r_vld        <= 1'b1;
          r_band       <= r_cur;
          r_ptr        <= (r_cur == BAND_W'(NUM_BANDS - 1)) ? '0 : r_cur + 1'b1;
`ifdef LED_SCHED_PEAK_EN
          // Attack instantly; decay by 1/16 per capture, never below the level.
          if (avg_out > r_pk[r_cur])  r_pk[r_cur] <= avg_out;
          else if (w_pk_dec < avg_out) r_pk[r_cur] <= avg_out;
          else                         r_pk[r_cur] <= w_pk_dec;
`endif
        end
        default: ;
      endcase
    end
  end

  assign avg_smpl = r_smpl;
  assign lvl_out  = r_lvl;
  assign lvl_vld  = r_vld;
  assign lvl_band = r_band;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_led_avg_sched.sv
// Directed bench for led_avg_sched with a behavioural averager
// (sum of smpl_in over the window, >>9). Build with LED_SCHED_PEAK_EN to
// exercise the peak-hold path as well.
module tb_led_avg_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  band_req;
  logic [63:0] band_smpl;
  logic [3:0]  band_gnt;
  logic        avg_seq;
  logic [15:0] avg_smpl;
  logic [15:0] avg_out;
  logic [63:0] lvl_out;
  logic        lvl_vld;
  logic [1:0]  lvl_band;
  logic        busy;
`ifdef LED_SCHED_PEAK_EN
  logic [63:0] pk_out;
`endif

  int checks = 0;
  int errs   = 0;

  led_avg_sched #(.NUM_BANDS(4), .WIN_LEN(1022), .SETTLE(3)) dut (
    .clk(clk), .rst(rst), .band_req(band_req), .band_smpl(band_smpl),
    .band_gnt(band_gnt), .avg_seq(avg_seq), .avg_smpl(avg_smpl),
    .avg_out(avg_out), .lvl_out(lvl_out), .lvl_vld(lvl_vld),
    .lvl_band(lvl_band),
`ifdef LED_SCHED_PEAK_EN
    .pk_out(pk_out),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural averager: accumulator restarts on a rising edge of sequencing.
  logic [31:0] acc = '0;
  logic        prev = 1'b0;
  always @(posedge clk) begin
    prev <= avg_seq;
    if (avg_seq) acc <= prev ? acc + 32'(avg_smpl) : 32'(avg_smpl);
  end
  assign avg_out = acc[24:9];

  typedef struct {
    logic [3:0]  req;
    logic [63:0] smpl;
    int          band;
    int          lvl;
    int          mag;
  } vec_t;
  vec_t tbl[6];

  function automatic logic [63:0] pk4(input int s0, input int s1, input int s2, input int s3);
    return {16'(s3), 16'(s2), 16'(s1), 16'(s0)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One grant from IDLE: latency, window length, magnitude, capture.
  task automatic run_one(input string nm, input logic [3:0] req, input logic [63:0] s,
                         input int band, input int lvl, input int mag, input int drop_at);
    int n, len, bad;
    @(negedge clk);
    band_smpl = s;
    band_req  = req;
    n = 0;
    do begin tick(); n++; end while (!avg_seq && n < 20);
    chk({nm, " latency"}, 64'(n), 64'd1);
    chk({nm, " gnt"}, 64'(band_gnt), 64'(1) << band);
    len = 0; bad = 0;
    while (avg_seq && len < 2000) begin
      len++;
      if (avg_smpl != 16'(mag)) bad++;
      if (len == drop_at) band_req = '0;
      tick();
    end
    chk({nm, " win_len"}, 64'(len), 64'd1022);
    chk({nm, " avg_smpl bad cycles"}, 64'(bad), 64'd0);
    n = 0;
    while (!lvl_vld && n < 20) begin tick(); n++; end
    chk({nm, " settle+capt cycles"}, 64'(n), 64'd4);
    chk({nm, " lvl_band"}, 64'(lvl_band), 64'(band));
    chk({nm, " lvl"}, 64'(lvl_out[16*band +: 16]), 64'(lvl));
  endtask

  initial begin
    int n, t, tprev, nb;
    int exp4[4];

    tbl[0] = '{req: 4'b0010, smpl: pk4(0, -100, 0, 0),    band: 1, lvl: 199,   mag: 100};
    tbl[1] = '{req: 4'b0100, smpl: pk4(0, 0, -32768, 0),  band: 2, lvl: 65406, mag: 32767};
    tbl[2] = '{req: 4'b1000, smpl: pk4(0, 0, 0, 1000),    band: 3, lvl: 1996,  mag: 1000};
    tbl[3] = '{req: 4'b0001, smpl: pk4(512, 0, 0, 0),     band: 0, lvl: 1022,  mag: 512};
    tbl[4] = '{req: 4'b0101, smpl: pk4(7, 0, -5, 0),      band: 2, lvl: 9,     mag: 5};
    tbl[5] = '{req: 4'b0011, smpl: pk4(7, 3, 0, 0),       band: 0, lvl: 13,    mag: 7};
    exp4 = '{199, 399, 598, 798};

    // Reset state
    rst = 1'b1; band_req = '0; band_smpl = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("rst band_gnt", 64'(band_gnt), 64'd0);
    chk("rst avg_seq",  64'(avg_seq),  64'd0);
    chk("rst avg_smpl", 64'(avg_smpl), 64'd0);
    chk("rst lvl_out",  lvl_out,       64'd0);
    chk("rst lvl_vld",  64'(lvl_vld),  64'd0);
    chk("rst lvl_band", 64'(lvl_band), 64'd0);
    chk("rst busy",     64'(busy),     64'd0);

    // Single band 1 at -100; other levels untouched
    run_one("single", 4'b0010, pk4(0, -100, 0, 0), 1, 199, 100, 1);
    chk("single others zero", {lvl_out[63:32], lvl_out[15:0]}, 64'd0);

    // Request dropped 10 cycles into the window: still runs and captures
    run_one("drop", 4'b0010, pk4(0, -300, 0, 0), 1, 598, 300, 10);
    nb = 0;
    repeat (20) begin tick(); if (busy) nb++; end
    chk("drop no regrant", 64'(nb), 64'd0);

    // Reset at SEQ cycle 500
    @(negedge clk); band_smpl = pk4(0, 0, 0, 50); band_req = 4'b1000;
    n = 0;
    do begin tick(); n++; end while (!avg_seq && n < 20);
    chk("midrst gnt", 64'(band_gnt), 64'b1000);
    repeat (499) tick();
    @(negedge clk); rst = 1'b1;
    tick();
    chk("midrst avg_seq",  64'(avg_seq),  64'd0);
    chk("midrst band_gnt", 64'(band_gnt), 64'd0);
    chk("midrst lvl_out",  lvl_out,       64'd0);
    chk("midrst busy",     64'(busy),     64'd0);
    chk("midrst lvl_vld",  64'(lvl_vld),  64'd0);
    @(negedge clk); rst = 1'b0; band_req = 4'hF;
    tick();
    chk("midrst restart band0", 64'(band_gnt), 64'b0001);
    @(negedge clk); rst = 1'b1; band_req = '0;
    @(negedge clk); rst = 1'b0;

    // All four bands requesting: order 0,1,2,3,0, period 1027, one IDLE cycle
    @(negedge clk); band_smpl = pk4(100, 200, 300, 400); band_req = 4'hF;
    tprev = 0;
    for (int w = 0; w < 5; w++) begin
      n = 0;
      while (!lvl_vld && n < 1100) begin tick(); n++; end
      t = cycle_now();
      chk($sformatf("rr%0d vld", w), 64'(lvl_vld), 64'd1);
      chk($sformatf("rr%0d band", w), 64'(lvl_band), 64'(w % 4));
      chk($sformatf("rr%0d lvl", w), 64'(lvl_out[16*(w%4) +: 16]), 64'(exp4[w%4]));
      chk($sformatf("rr%0d idle", w), 64'(busy), 64'd0);
      if (w > 0) chk($sformatf("rr%0d period", w), 64'(t - tprev), 64'd1027);
      tprev = t;
      tick();
      if (w < 4) chk($sformatf("rr%0d next seq", w), 64'(avg_seq), 64'd1);
      else       chk("rr no regrant", 64'(avg_seq), 64'd0);
      if (w == 3) band_req = '0;
    end

    // Table: circular search and magnitude corners (rr_ptr starts at 1)
    for (int i = 0; i < 6; i++)
      run_one($sformatf("vec%0d", i), tbl[i].req, tbl[i].smpl,
              tbl[i].band, tbl[i].lvl, tbl[i].mag, 1);

`ifdef LED_SCHED_PEAK_EN
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    run_one("pk1", 4'b0001, pk4(802, 0, 0, 0), 0, 1600, 802, 1);
    chk("pk attack", 64'(pk_out[15:0]), 64'd1600);
    run_one("pk2", 4'b0001, pk4(401, 0, 0, 0), 0, 800, 401, 1);
    chk("pk decay", 64'(pk_out[15:0]), 64'd1500);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int cycle_now();
    return cyc;
  endfunction

endmodule
